// File: rtl/cal1d_pool_sum_ctrl.sv
// cal1d_pool_sum_ctrl
// Window-accumulation sequencer for the 4-lane fp17 1-D pooling sum path.
// Folds each run of K = cfg_kernel_width + 1 input elements into one pooled
// sum by issuing one acc + element add at a time to an external sum unit.
//
// Ports:
//   autosa_core_clk / autosa_core_rstn : clock, async active-low reset
//   op_en, cfg_kernel_width            : window start enable / length - 1
//   in_pvld / in_prdy / in_pd          : input element stream (4 x fp17)
//   sum_in_* / sum_a / sum_b           : add request to the sum unit
//   sum_out_* / sum_z                  : add result from the sum unit
//   out_pvld / out_prdy / out_pd       : pooled result (one per window)
//   busy, win_cnt                      : status, completed-window count
module cal1d_pool_sum_ctrl #(
    parameter int unsigned KW_BITS = 3,
    localparam int unsigned PD_W   = 68,
    localparam int unsigned CNT_W  = KW_BITS + 1,
    localparam int unsigned WC_W   = 16
) (
    input  logic                autosa_core_clk,
    input  logic                autosa_core_rstn,
    input  logic                op_en,
    input  logic [KW_BITS-1:0]  cfg_kernel_width,
    input  logic                in_pvld,
    output logic                in_prdy,
    input  logic [PD_W-1:0]     in_pd,
    output logic                sum_in_pvld,
    input  logic                sum_in_prdy,
    output logic [PD_W-1:0]     sum_a,
    output logic [PD_W-1:0]     sum_b,
    input  logic                sum_out_pvld,
    output logic                sum_out_prdy,
    input  logic [PD_W-1:0]     sum_z,
    output logic                out_pvld,
    input  logic                out_prdy,
    output logic [PD_W-1:0]     out_pd,
    output logic                busy,
    output logic [WC_W-1:0]     win_cnt
);

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] HOLD  = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] OUT   = 2'd3;

    logic [1:0]         state, state_nxt;
    logic [PD_W-1:0]    acc, acc_nxt;
    logic [KW_BITS-1:0] kw, kw_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [WC_W-1:0]    win_cnt_nxt;

    // State and datapath registers
    always_ff @(posedge autosa_core_clk or negedge autosa_core_rstn) begin
        if (!autosa_core_rstn) begin
            state   <= EMPTY;
            acc     <= '0;
            kw      <= '0;
            cnt     <= '0;
            win_cnt <= '0;
        end else begin
            state   <= state_nxt;
            acc     <= acc_nxt;
            kw      <= kw_nxt;
            cnt     <= cnt_nxt;
            win_cnt <= win_cnt_nxt;
        end
    end

    // Next-state, register updates and handshake routing
    always_comb begin
        state_nxt    = state;
        acc_nxt      = acc;
        kw_nxt       = kw;
        cnt_nxt      = cnt;
        win_cnt_nxt  = win_cnt;
        in_prdy      = 1'b0;
        sum_in_pvld  = 1'b0;
        sum_out_prdy = 1'b0;
        out_pvld     = 1'b0;

        case (state)
            EMPTY: begin
                in_prdy = op_en;
                if (in_pvld && op_en) begin
                    acc_nxt   = in_pd;
                    kw_nxt    = cfg_kernel_width;
                    cnt_nxt   = CNT_W'(1);
                    state_nxt = (cfg_kernel_width == '0) ? OUT : HOLD;
                end
            end
            HOLD: begin
                // Operands pass straight through; the element is consumed
                // only when the sum unit takes it.
                sum_in_pvld = in_pvld;
                in_prdy     = sum_in_prdy;
                if (in_pvld && sum_in_prdy) begin
                    cnt_nxt   = cnt + CNT_W'(1);
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                sum_out_prdy = 1'b1;
                if (sum_out_pvld) begin
                    acc_nxt   = sum_z;
                    // cnt is one bit wider than kw so K = 2^KW_BITS fits
                    state_nxt = (cnt == ({1'b0, kw} + CNT_W'(1))) ? OUT : HOLD;
                end
            end
            OUT: begin
                out_pvld = 1'b1;
                if (out_prdy) begin
                    win_cnt_nxt = win_cnt + WC_W'(1);
                    state_nxt   = EMPTY;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    // Data buses are never gated; only the valids qualify them
    assign sum_a  = acc;
    assign sum_b  = in_pd;
    assign out_pd = acc;
    assign busy   = (state != EMPTY);

endmodule

// File: tb/tb_cal1d_pool_sum_ctrl.sv
// tb_cal1d_pool_sum_ctrl
// Directed bench for cal1d_pool_sum_ctrl with a latency-3 fp17 sum model
// and optional random back-pressure on sum_in_prdy.
module tb_cal1d_pool_sum_ctrl;

    localparam int unsigned KW_BITS = 3;
    localparam int unsigned LAT     = 3;

    localparam logic [16:0] F1 = 17'h07C00;
    localparam logic [16:0] F2 = 17'h08000;
    localparam logic [16:0] F3 = 17'h08200;
    localparam logic [16:0] F4 = 17'h08400;

    logic               clk = 1'b0;
    logic               rstn;
    logic               op_en;
    logic [KW_BITS-1:0] cfg;
    logic               in_pvld;
    logic               in_prdy;
    logic [67:0]        in_pd;
    logic               sum_in_pvld;
    logic               sum_in_prdy;
    logic [67:0]        sum_a;
    logic [67:0]        sum_b;
    logic               sum_out_pvld;
    logic               sum_out_prdy;
    logic [67:0]        sum_z;
    logic               out_pvld;
    logic               out_prdy;
    logic [67:0]        out_pd;
    logic               busy;
    logic [15:0]        win_cnt;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int exp_win = 0;
    int proto_err = 0;
    logic bp_en = 1'b0;

    cal1d_pool_sum_ctrl #(.KW_BITS(KW_BITS)) dut (
        .autosa_core_clk  (clk),
        .autosa_core_rstn (rstn),
        .op_en            (op_en),
        .cfg_kernel_width (cfg),
        .in_pvld          (in_pvld),
        .in_prdy          (in_prdy),
        .in_pd            (in_pd),
        .sum_in_pvld      (sum_in_pvld),
        .sum_in_prdy      (sum_in_prdy),
        .sum_a            (sum_a),
        .sum_b            (sum_b),
        .sum_out_pvld     (sum_out_pvld),
        .sum_out_prdy     (sum_out_prdy),
        .sum_z            (sum_z),
        .out_pvld         (out_pvld),
        .out_prdy         (out_prdy),
        .out_pd           (out_pd),
        .busy             (busy),
        .win_cnt          (win_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [67:0] obs, input logic [67:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [67:0] rep(input logic [16:0] x);
        return {x, x, x, x};
    endfunction

    // fp17: 1 sign, 6 exponent (bias 31), 10 mantissa; positive values only
    function automatic real f2r(input logic [16:0] x);
        int  e;
        real v;
        e = int'(x[15:10]);
        if (e == 0) return 0.0;
        v = 1.0 + real'(int'(x[9:0])) / 1024.0;
        for (int i = 31; i < e; i++) v = v * 2.0;
        for (int i = e; i < 31; i++) v = v / 2.0;
        return v;
    endfunction

    function automatic logic [16:0] r2f(input real v);
        int  e;
        real f;
        if (v == 0.0) return 17'h0;
        e = 31;
        f = v;
        while (f >= 2.0) begin f = f / 2.0; e++; end
        while (f < 1.0)  begin f = f * 2.0; e--; end
        return {1'b0, 6'(e), 10'(int'((f - 1.0) * 1024.0))};
    endfunction

    function automatic logic [67:0] add4(input logic [67:0] a, input logic [67:0] b);
        logic [67:0] r;
        for (int i = 0; i < 4; i++)
            r[17*i +: 17] = r2f(f2r(a[17*i +: 17]) + f2r(b[17*i +: 17]));
        return r;
    endfunction

    // Sum unit model: one add in flight, result valid LAT cycles after accept
    logic        pend;
    int          dly;
    logic [67:0] log_a[$];
    logic [67:0] log_b[$];

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pend  <= 1'b0;
            dly   <= 0;
            sum_z <= '0;
        end else begin
            if (pend) begin
                if (dly != 0) dly <= dly - 1;
                else if (sum_out_prdy) pend <= 1'b0;
            end
            if (sum_in_pvld && sum_in_prdy) begin
                if (pend) proto_err++;
                pend  <= 1'b1;
                dly   <= LAT - 1;
                sum_z <= add4(sum_a, sum_b);
                log_a.push_back(sum_a);
                log_b.push_back(sum_b);
            end
        end
    end

    assign sum_out_pvld = pend && (dly == 0);

    always @(negedge clk)
        sum_in_prdy = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;

    // Offer one element; returns the cycle number in which it was accepted
    task automatic send_elem(input logic [67:0] pd, output int acc_cyc);
        in_pvld = 1'b1;
        in_pd   = pd;
        for (int i = 0; i < 100; i++) begin
            #1;
            if (in_prdy) begin
                acc_cyc = cyc;
                @(negedge clk);
                in_pvld = 1'b0;
                return;
            end
            @(negedge clk);
        end
        chk("accept_timeout", 68'(in_prdy), 68'(1));
        in_pvld = 1'b0;
        acc_cyc = cyc;
    endtask

    task automatic wait_out(output int seen_cyc);
        for (int i = 0; i < 200; i++) begin
            if (out_pvld) begin
                seen_cyc = cyc;
                return;
            end
            @(negedge clk);
        end
        chk("out_timeout", 68'(out_pvld), 68'(1));
        seen_cyc = cyc;
    endtask

    task automatic take_out();
        out_prdy = 1'b1;
        @(negedge clk);
        out_prdy = 1'b0;
        exp_win++;
        chk("win_cnt", 68'(win_cnt), 68'(exp_win));
        chk("out_drop", 68'(out_pvld), 68'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, t1, tx;
        logic [67:0] lanes;

        // Reset values
        rstn = 1'b0; op_en = 1'b0; cfg = '0; in_pvld = 1'b0; out_prdy = 1'b0;
        in_pd = 68'h1_2345_6789_ABCD_EF01;
        #2;
        chk("rst_in_prdy0", 68'(in_prdy), 68'(0));
        chk("rst_sum_in_pvld", 68'(sum_in_pvld), 68'(0));
        chk("rst_sum_out_prdy", 68'(sum_out_prdy), 68'(0));
        chk("rst_out_pvld", 68'(out_pvld), 68'(0));
        chk("rst_busy", 68'(busy), 68'(0));
        chk("rst_win_cnt", 68'(win_cnt), 68'(0));
        chk("rst_out_pd", out_pd, 68'(0));
        chk("rst_sum_a", sum_a, 68'(0));
        chk("rst_sum_b", sum_b, 68'h1_2345_6789_ABCD_EF01);
        op_en = 1'b1;
        #1;
        chk("rst_in_prdy1", 68'(in_prdy), 68'(1));
        @(negedge clk); @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        // K = 1: output one cycle after acceptance, no adds
        log_a.delete(); log_b.delete();
        cfg = 3'd0;
        send_elem(rep(F1), t0);
        wait_out(t1);
        chk("k1_latency", 68'(t1 - t0), 68'(1));
        chk("k1_out_pd", out_pd, rep(F1));
        chk("k1_busy", 68'(busy), 68'(1));
        take_out();
        chk("k1_nadds", 68'(log_a.size()), 68'(0));

        // K = 4, no stalls: 1 + 3*(3+1) = 13 cycles to output
        log_a.delete(); log_b.delete();
        cfg = 3'd3;
        send_elem(rep(F1), t0);
        for (int i = 0; i < 3; i++) send_elem(rep(F1), tx);
        wait_out(t1);
        chk("k4_latency", 68'(t1 - t0), 68'(13));
        chk("k4_out_pd", out_pd, rep(F4));
        chk("k4_nadds", 68'(log_a.size()), 68'(3));
        if (log_a.size() == 3) begin
            chk("k4_a0", log_a[0], rep(F1));
            chk("k4_a1", log_a[1], rep(F2));
            chk("k4_a2", log_a[2], rep(F3));
            for (int i = 0; i < 3; i++) chk("k4_b", log_b[i], rep(F1));
        end
        take_out();

        // K = 2 with sum back-pressure and a 10-cycle out_prdy stall
        log_a.delete(); log_b.delete();
        bp_en = 1'b1;
        cfg = 3'd1;
        send_elem(rep(F1), t0);
        send_elem(rep(F1), tx);
        wait_out(t1);
        in_pvld = 1'b1;
        in_pd   = rep(F4);
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("bp_out_pvld", 68'(out_pvld), 68'(1));
            chk("bp_out_pd", out_pd, rep(F2));
            chk("bp_in_prdy", 68'(in_prdy), 68'(0));
            @(negedge clk);
        end
        out_prdy = 1'b1;
        @(negedge clk);
        out_prdy = 1'b0;
        in_pvld  = 1'b0;
        exp_win++;
        chk("bp_win_cnt", 68'(win_cnt), 68'(exp_win));
        chk("bp_out_drop", 68'(out_pvld), 68'(0));
        chk("bp_nadds", 68'(log_a.size()), 68'(1));

        // K = 3 with distinct lanes: {4,3,2,1} x 3 = {12,9,6,3}
        lanes = {F4, F3, F2, F1};
        cfg = 3'd2;
        for (int i = 0; i < 3; i++) send_elem(lanes, tx);
        wait_out(t1);
        chk("k3_out_pd", out_pd, {17'h08A00, 17'h08880, 17'h08600, 17'h08200});
        take_out();

        // Config change mid-window: window keeps K = 4, next one uses K = 1
        log_a.delete(); log_b.delete();
        cfg = 3'd3;
        send_elem(rep(F1), t0);
        cfg = 3'd0;
        for (int i = 0; i < 3; i++) send_elem(rep(F1), tx);
        wait_out(t1);
        chk("cfg_out_pd", out_pd, rep(F4));
        chk("cfg_nadds", 68'(log_a.size()), 68'(3));
        take_out();
        send_elem(rep(F2), t0);
        wait_out(t1);
        chk("cfg_k1_latency", 68'(t1 - t0), 68'(1));
        chk("cfg_k1_out_pd", out_pd, rep(F2));
        take_out();
        bp_en = 1'b0;

        // op_en low blocks acceptance; raising it accepts in that cycle
        op_en = 1'b0; in_pvld = 1'b1; in_pd = rep(F3);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("open_in_prdy", 68'(in_prdy), 68'(0));
            chk("open_busy", 68'(busy), 68'(0));
            @(negedge clk);
        end
        op_en = 1'b1;
        #1;
        chk("open_accept", 68'(in_prdy), 68'(1));
        @(negedge clk);
        in_pvld = 1'b0;
        chk("open_busy_after", 68'(busy), 68'(1));
        chk("open_out_pd", out_pd, rep(F3));
        take_out();

        // Reset during an outstanding add
        cfg = 3'd1;
        send_elem(rep(F1), t0);
        send_elem(rep(F1), tx);
        chk("mid_busy", 68'(busy), 68'(1));
        chk("mid_sum_out_prdy", 68'(sum_out_prdy), 68'(1));
        #2;
        rstn = 1'b0;
        #1;
        chk("mid_rst_busy", 68'(busy), 68'(0));
        chk("mid_rst_sum_out_prdy", 68'(sum_out_prdy), 68'(0));
        chk("mid_rst_out_pvld", 68'(out_pvld), 68'(0));
        chk("mid_rst_sum_in_pvld", 68'(sum_in_pvld), 68'(0));
        chk("mid_rst_win_cnt", 68'(win_cnt), 68'(0));
        chk("mid_rst_out_pd", out_pd, 68'(0));
        chk("mid_rst_in_prdy", 68'(in_prdy), 68'(1));
        @(negedge clk);
        rstn = 1'b1;
        exp_win = 0;
        @(negedge clk);
        send_elem(rep(F1), t0);
        send_elem(rep(F1), tx);
        wait_out(t1);
        chk("post_rst_out_pd", out_pd, rep(F2));
        take_out();

        chk("sum_protocol", 68'(proto_err), 68'(0));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
